// File: rtl/rst_seq_ctrl.sv
// Reset / clock-enable sequencer: releases sysrst_n, rst_n, then clk_en after programmable delays,
// runs for an optional bounded window, then shuts down. Optional RST_SEQ_CYCLE_CNT_EN adds run_cycles_o.
module rst_seq_ctrl #(
    parameter int unsigned SYS_DLY   = 10,
    parameter int unsigned RST_DLY   = 10,
    parameter int unsigned CLK_DLY   = 20,
    parameter int unsigned RUN_LIMIT = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic        sysrst_n_o,
    output logic        rst_n_o,
    output logic        clk_en_o,
    output logic [2:0]  state_o,
    output logic        busy_o,
    output logic        done_o
`ifdef RST_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0] run_cycles_o
`endif
);

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StSysWait = 3'd1,
        StRstWait = 3'd2,
        StClkWait = 3'd3,
        StRun     = 3'd4,
        StStop    = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] SysLast = CNT_W'(SYS_DLY - 1);
    localparam logic [CNT_W-1:0] RstLast = CNT_W'(RST_DLY - 1);
    localparam logic [CNT_W-1:0] ClkLast = CNT_W'(CLK_DLY - 1);
    localparam logic [CNT_W-1:0] RunLast = CNT_W'(RUN_LIMIT - 1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic             sysrst_n_q, sysrst_n_d;
    logic             rst_n_q, rst_n_d;
    logic             clk_en_q, clk_en_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] dly_last;
    state_e           dly_next;

    // Terminal count and successor for whichever delay state is current
    always_comb begin
        dly_last = SysLast;
        dly_next = StRstWait;
        case (state_q)
            StRstWait: begin
                dly_last = RstLast;
                dly_next = StClkWait;
            end
            StClkWait: begin
                dly_last = ClkLast;
                dly_next = StRun;
            end
            default: begin
                dly_last = SysLast;
                dly_next = StRstWait;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = start_i ? armed_q : 1'b1;
        done_d  = 1'b0;
        case (state_q)
            StOff: begin
                cnt_d = '0;
                if (start_i && armed_q) begin
                    state_d = StSysWait;
                    armed_d = 1'b0;
                end
            end
            StSysWait, StRstWait, StClkWait: begin
                if (!start_i || stop_i) begin
                    state_d = StOff;
                    cnt_d   = '0;
                end else if (cnt_q == dly_last) begin
                    state_d = dly_next;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (stop_i || (RUN_LIMIT != 0 && cnt_q == RunLast)) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                state_d = StOff;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StOff;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it
    always_comb begin
        sysrst_n_d = 1'b0;
        rst_n_d    = 1'b0;
        clk_en_d   = 1'b0;
        busy_d     = (state_d != StOff);
        case (state_d)
            StRstWait: sysrst_n_d = 1'b1;
            StClkWait: begin
                sysrst_n_d = 1'b1;
                rst_n_d    = 1'b1;
            end
            StRun: begin
                sysrst_n_d = 1'b1;
                rst_n_d    = 1'b1;
                clk_en_d   = 1'b1;
            end
            StStop: sysrst_n_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            done_q     <= 1'b0;
            sysrst_n_q <= 1'b0;
            rst_n_q    <= 1'b0;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            sysrst_n_q <= sysrst_n_d;
            rst_n_q    <= rst_n_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
        end
    end

    assign state_o    = state_q;
    assign sysrst_n_o = sysrst_n_q;
    assign rst_n_o    = rst_n_q;
    assign clk_en_o   = clk_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

`ifdef RST_SEQ_CYCLE_CNT_EN
    logic [31:0] run_cycles_q, run_cycles_d;

    always_comb begin
        run_cycles_d = run_cycles_q;
        if (state_q == StOff && state_d == StSysWait) begin
            run_cycles_d = '0;
        end else if (state_q == StRun && run_cycles_q != 32'hFFFF_FFFF) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_cycles_q <= '0;
        end else begin
            run_cycles_q <= run_cycles_d;
        end
    end

    assign run_cycles_o = run_cycles_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: two instances (unlimited run, RUN_LIMIT=5) driven by directed and random
// stimulus and compared every cycle against a phase/elapsed-time reference model.
module tb_rst_seq_ctrl;

    localparam int Lim1 = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop;
    logic       sysrst_n0, rst_n0, clk_en0, busy0, done0;
    logic       sysrst_n1, rst_n1, clk_en1, busy1, done1;
    logic [2:0] state0, state1;
`ifdef RST_SEQ_CYCLE_CNT_EN
    logic [31:0] rc0, rc1;
`endif

    rst_seq_ctrl #(.RUN_LIMIT(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .sysrst_n_o(sysrst_n0), .rst_n_o(rst_n0), .clk_en_o(clk_en0),
        .state_o(state0), .busy_o(busy0), .done_o(done0)
`ifdef RST_SEQ_CYCLE_CNT_EN
        , .run_cycles_o(rc0)
`endif
    );

    rst_seq_ctrl #(.RUN_LIMIT(Lim1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
        .sysrst_n_o(sysrst_n1), .rst_n_o(rst_n1), .clk_en_o(clk_en1),
        .state_o(state1), .busy_o(busy1), .done_o(done1)
`ifdef RST_SEQ_CYCLE_CNT_EN
        , .run_cycles_o(rc1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int edge_num = 0;

    // Model: phase 0 off, 1..3 delay phases, 4 running, 5 stopping
    int     m_phase[2];
    int     m_el[2];
    bit     m_armed[2];
    bit     m_done[2];
    longint m_rc[2];
    int     lim[2];

    function automatic int dly_of(input int p);
        return (p == 3) ? 20 : 10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_num);
        end
    endtask

    task automatic model_step(input int i, input bit st, input bit sp, input bit r);
        if (r) begin
            m_phase[i] = 0; m_el[i] = 0; m_armed[i] = 1'b1; m_done[i] = 1'b0; m_rc[i] = 0;
            return;
        end
        m_done[i] = 1'b0;
        case (m_phase[i])
            0: if (st && m_armed[i]) begin
                m_phase[i] = 1; m_el[i] = 0; m_armed[i] = 1'b0; m_rc[i] = 0;
            end
            1, 2, 3: begin
                if (!st || sp) begin
                    m_phase[i] = 0; m_el[i] = 0;
                end else if (m_el[i] + 1 == dly_of(m_phase[i])) begin
                    m_phase[i]++; m_el[i] = 0;
                end else begin
                    m_el[i]++;
                end
            end
            4: begin
                if (m_rc[i] < 64'hFFFF_FFFF) m_rc[i]++;
                if (sp || (lim[i] != 0 && m_el[i] + 1 == lim[i])) begin
                    m_phase[i] = 5; m_el[i] = 0;
                end else begin
                    m_el[i]++;
                end
            end
            default: begin
                m_phase[i] = 0; m_done[i] = 1'b1;
            end
        endcase
        if (!st) m_armed[i] = 1'b1;
    endtask

    function automatic logic [7:0] exp_vec(input int i);
        int p;
        p = m_phase[i];
        return {3'(p), (p >= 2), (p == 3 || p == 4), (p == 4), (p != 0), m_done[i]};
    endfunction

    task automatic check_all();
        chk("outs_unlim", {24'd0, state0, sysrst_n0, rst_n0, clk_en0, busy0, done0},
            {24'd0, exp_vec(0)});
        chk("outs_lim5", {24'd0, state1, sysrst_n1, rst_n1, clk_en1, busy1, done1},
            {24'd0, exp_vec(1)});
`ifdef RST_SEQ_CYCLE_CNT_EN
        chk("run_cycles_unlim", rc0, m_rc[0][31:0]);
        chk("run_cycles_lim5", rc1, m_rc[1][31:0]);
`endif
    endtask

    task automatic cycle(input bit st, input bit sp, input bit r);
        rst = r; start = st; stop = sp;
        @(posedge clk);
        model_step(0, st, sp, r);
        model_step(1, st, sp, r);
        edge_num++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int t_sys, t_rst, t_clk, t_done0, t_done1;
        bit st, sp, r;
        lim[0] = 0; lim[1] = Lim1;
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_el[i] = 0; m_armed[i] = 1'b1; m_done[i] = 1'b0; m_rc[i] = 0;
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0;

        // Reset for 3 cycles, then start held high from edge 0; stop pulse samples at edge 61
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        edge_num = 0;
        t_sys = -1; t_rst = -1; t_clk = -1; t_done0 = -1; t_done1 = -1;
        for (int e = 1; e <= 70; e++) begin
            cycle(1'b1, e == 61, 1'b0);
            if (sysrst_n0 && t_sys < 0) t_sys = edge_num;
            if (rst_n0 && t_rst < 0) t_rst = edge_num;
            if (clk_en0 && t_clk < 0) t_clk = edge_num;
            if (done0 && t_done0 < 0) t_done0 = edge_num;
            if (done1 && t_done1 < 0) t_done1 = edge_num;
        end
        chk("sysrst_n_rise_edge", 32'(t_sys), 32'd11);
        chk("rst_n_rise_edge", 32'(t_rst), 32'd21);
        chk("clk_en_rise_edge", 32'(t_clk), 32'd41);
        chk("done_lim5_edge", 32'(t_done1), 32'd47);
        chk("done_stop_edge", 32'(t_done0), 32'd62);
        chk("lim5_no_restart", {29'd0, state1}, 32'd0);

        // Stop pulses while off are ignored
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);

        // Abort in RST_WAIT, restart, reset in CLK_WAIT, then reset together with stop in RUN
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        edge_num = 0;
        for (int e = 1; e <= 140; e++) begin
            cycle(e != 16, e == 130, (e == 45) || (e == 130));
            if (e == 16) chk("abort_state", {29'd0, state0}, 32'd0);
        end

        // Randomized operation
        for (int n = 0; n < 4000; n++) begin
            st = ($urandom_range(0, 39) != 0);
            sp = ($urandom_range(0, 79) == 0);
            r  = ($urandom_range(0, 299) == 0);
            cycle(st, sp, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
